// File: rtl/button_conditioner.sv
// Synchronises, debounces and auto-repeats the active-low front-panel buttons.
// States: IDLE released | PRESS_CHK confirming press | HELD accepted | REPEAT auto-repeating | REL_CHK confirming release
module button_conditioner #(
  parameter int                     NUM_BUTTONS    = 6,
  parameter int                     DEBOUNCE_TICKS = 4,
  parameter int                     HOLD_TICKS     = 5000,
  parameter int                     REPEAT_TICKS   = 1000,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK    = 6'b111100
) (
  input  logic                   clk_2M5,
  input  logic                   reset_n,
  input  logic                   debounce_pulse,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press
);

  localparam int HMAX   = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HCNT_W = $clog2(HMAX + 1);
  localparam int CNT_W  = DEBOUNCE_TICKS;

  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DONE    = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [HCNT_W-1:0] HCNT_ONE    = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] HOLD_DONE   = HCNT_W'(HOLD_TICKS);
  localparam logic [HCNT_W-1:0] REPEAT_DONE = HCNT_W'(REPEAT_TICKS);

  typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, REPEAT, REL_CHK} state_t;

  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic                   dp_q, dp_d, dp_prev_q, dp_prev_d;
  logic [NUM_BUTTONS-1:0] level_q, level_d, press_q, press_d;
  state_t                 state_q [NUM_BUTTONS];
  state_t                 state_d [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_q   [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_d   [NUM_BUTTONS];
  logic [HCNT_W-1:0]      hcnt_q  [NUM_BUTTONS];
  logic [HCNT_W-1:0]      hcnt_d  [NUM_BUTTONS];

  logic                   tick;
  logic [NUM_BUTTONS-1:0] pressed;

  assign tick    = dp_q & ~dp_prev_q;
  assign pressed = ~sync2_q;

  always_comb begin
    sync1_d   = buttons_n;
    sync2_d   = sync1_q;
    dp_d      = debounce_pulse;
    dp_prev_d = dp_q;
    level_d   = level_q;
    press_d   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hcnt_d[i]  = hcnt_q[i];
      if (tick) begin
        case (state_q[i])
          IDLE: begin
            if (pressed[i]) begin
              state_d[i] = PRESS_CHK;
              cnt_d[i]   = CNT_ONE;
            end
          end
          PRESS_CHK: begin
            if (pressed[i]) begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
              if (cnt_q[i] + CNT_ONE == CNT_DONE) begin
                state_d[i] = HELD;
                level_d[i] = 1'b1;
                press_d[i] = 1'b1;
                hcnt_d[i]  = '0;
              end
            end else begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end
          end
          HELD: begin
            if (!pressed[i]) begin
              state_d[i] = REL_CHK;
              cnt_d[i]   = CNT_ONE;
            end else if (REPEAT_MASK[i]) begin
              hcnt_d[i] = hcnt_q[i] + HCNT_ONE;
              if (hcnt_q[i] + HCNT_ONE == HOLD_DONE) begin
                state_d[i] = REPEAT;
                press_d[i] = 1'b1;
                hcnt_d[i]  = '0;
              end
            end else if (hcnt_q[i] != HOLD_DONE) begin
              hcnt_d[i] = hcnt_q[i] + HCNT_ONE;
            end
          end
          REPEAT: begin
            if (pressed[i]) begin
              hcnt_d[i] = hcnt_q[i] + HCNT_ONE;
              if (hcnt_q[i] + HCNT_ONE == REPEAT_DONE) begin
                press_d[i] = 1'b1;
                hcnt_d[i]  = '0;
              end
            end else begin
              state_d[i] = REL_CHK;
              cnt_d[i]   = CNT_ONE;
            end
          end
          REL_CHK: begin
            // a press seen while confirming release re-arms the full hold delay
            if (pressed[i]) begin
              state_d[i] = HELD;
              hcnt_d[i]  = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
              if (cnt_q[i] + CNT_ONE == CNT_DONE) begin
                state_d[i] = IDLE;
                level_d[i] = 1'b0;
                cnt_d[i]   = '0;
              end
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            hcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_2M5) begin
    if (!reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      dp_q      <= 1'b0;
      dp_prev_q <= 1'b0;
      level_q   <= '0;
      press_q   <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        hcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      dp_q      <= dp_d;
      dp_prev_q <= dp_prev_d;
      level_q   <= level_d;
      press_q   <= press_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: one debounce period per call, outputs
// compared per tick against a run-length model of the debounce and repeat rules.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int NB   = 6;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam int HALF = 20;
  localparam logic [NB-1:0] MASK = 6'b111100;

  logic          clk_2M5 = 1'b0;
  logic          reset_n = 1'b0;
  logic          debounce_pulse = 1'b0;
  logic [NB-1:0] buttons_n = '1;
  logic [NB-1:0] btn_level, btn_press;

  int checks = 0;
  int failures = 0;

  button_conditioner #(
    .NUM_BUTTONS(NB), .DEBOUNCE_TICKS(DB), .HOLD_TICKS(HOLD),
    .REPEAT_TICKS(REP), .REPEAT_MASK(MASK)
  ) dut (
    .clk_2M5(clk_2M5), .reset_n(reset_n), .debounce_pulse(debounce_pulse),
    .buttons_n(buttons_n), .btn_level(btn_level), .btn_press(btn_press)
  );

  always #200 clk_2M5 = ~clk_2M5;

  int            press_tot [NB] = '{default: 0};
  int            wide_tot = 0;
  logic [NB-1:0] press_prev = '0;

  always @(negedge clk_2M5) begin
    for (int b = 0; b < NB; b++) begin
      if (btn_press[b] === 1'b1) press_tot[b]++;
      if (btn_press[b] === 1'b1 && press_prev[b] === 1'b1) wide_tot++;
    end
    press_prev = btn_press;
  end

  // reference model: debounce as run lengths, repeat as arithmetic on hold time
  int m_level [NB];
  int m_prun  [NB];
  int m_rrun  [NB];
  int m_run   [NB];

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_level[b] = 0; m_prun[b] = 0; m_rrun[b] = 0; m_run[b] = 0;
    end
  endtask

  task automatic model_tick(input logic [NB-1:0] pr, output logic [NB-1:0] ep, output logic [NB-1:0] el);
    for (int b = 0; b < NB; b++) begin
      ep[b] = 1'b0;
      if (m_level[b] == 0) begin
        if (pr[b]) begin
          m_prun[b]++;
          if (m_prun[b] == DB) begin
            m_level[b] = 1; ep[b] = 1'b1; m_run[b] = 0; m_rrun[b] = 0; m_prun[b] = 0;
          end
        end else m_prun[b] = 0;
      end else begin
        if (!pr[b]) begin
          m_rrun[b]++;
          if (m_rrun[b] == DB) begin m_level[b] = 0; m_rrun[b] = 0; end
        end else if (m_rrun[b] > 0) begin
          m_rrun[b] = 0; m_run[b] = 0;
        end else begin
          m_run[b]++;
          if (MASK[b] && (m_run[b] == HOLD || (m_run[b] > HOLD && (m_run[b] - HOLD) % REP == 0)))
            ep[b] = 1'b1;
        end
      end
      el[b] = (m_level[b] != 0);
    end
  endtask

  // one debounce_pulse period: buttons applied, low half, then high half holding the tick
  task automatic run_tick(input logic [NB-1:0] pr, input bit bounce,
                          output logic [NB-1:0] obs_press, output logic [NB-1:0] obs_multi,
                          output logic [NB-1:0] obs_level);
    int snap [NB];
    for (int b = 0; b < NB; b++) snap[b] = press_tot[b];
    buttons_n = ~pr;
    for (int c = 0; c < 2 * HALF; c++) begin
      @(negedge clk_2M5);
      if (bounce && (c % 15) == 14) buttons_n = buttons_n ^ pr;
      if (c == HALF - 1) debounce_pulse = 1'b1;
    end
    obs_level = btn_level;
    debounce_pulse = 1'b0;
    for (int b = 0; b < NB; b++) begin
      obs_press[b] = (press_tot[b] - snap[b]) != 0;
      obs_multi[b] = (press_tot[b] - snap[b]) > 1;
    end
  endtask

  logic [NB-1:0] op, om, ol, ep, el;

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk_2M5);
    checks++;
    if (btn_level !== 6'b0 || btn_press !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs level=%b press=%b required 000000/000000", btn_level, btn_press);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk_2M5);
    checks++;
    if (btn_level !== 6'b0 || btn_press !== 6'b0) begin
      failures++;
      $display("FAIL reset_release level=%b press=%b required 000000/000000", btn_level, btn_press);
    end
    model_reset();
  endtask

  task automatic test_mode_press();
    int first = 0, npulse = 0;
    for (int t = 1; t <= 12; t++) begin
      run_tick((t <= 6) ? 6'b000001 : 6'b000000, 1'b0, op, om, ol);
      model_tick((t <= 6) ? 6'b000001 : 6'b000000, ep, el);
      if (op[0]) begin npulse++; if (first == 0) first = t; end
      checks++;
      if (op !== ep || om !== 6'b0 || ol !== el) begin
        failures++;
        $display("FAIL mode_press tick=%0d press=%b level=%b multi=%b required press=%b level=%b", t, op, ol, om, ep, el);
      end
    end
    checks++;
    if (first != 4 || npulse != 1) begin
      failures++;
      $display("FAIL mode_press_pulse first_tick=%0d pulses=%0d required 4/1", first, npulse);
    end
  endtask

  task automatic test_bounce();
    for (int t = 1; t <= 8; t++) begin
      run_tick((t <= 3) ? 6'b000100 : 6'b000000, (t <= 3), op, om, ol);
      model_tick(6'b000000, ep, el);
      checks++;
      if (op[2] !== 1'b0 || ol[2] !== 1'b0) begin
        failures++;
        $display("FAIL tl_bounce tick=%0d press2=%b level2=%b required 0/0", t, op[2], ol[2]);
      end
    end
  endtask

  task automatic test_repeat_br();
    int npulse = 0, sum = 0;
    for (int t = 1; t <= 35; t++) begin
      run_tick((t <= 30) ? 6'b100000 : 6'b000000, 1'b0, op, om, ol);
      model_tick((t <= 30) ? 6'b100000 : 6'b000000, ep, el);
      if (op[5]) begin npulse++; sum += t; end
      checks++;
      if (op !== ep || om !== 6'b0 || ol !== el) begin
        failures++;
        $display("FAIL br_repeat tick=%0d press=%b level=%b multi=%b required press=%b level=%b", t, op, ol, om, ep, el);
      end
    end
    checks++;
    if (npulse != 7 || sum != 133) begin
      failures++;
      $display("FAIL br_repeat_total pulses=%0d tick_sum=%0d required 7/133", npulse, sum);
    end
  endtask

  task automatic test_no_repeat_load();
    int npulse = 0;
    for (int t = 1; t <= 35; t++) begin
      run_tick((t <= 30) ? 6'b000010 : 6'b000000, 1'b0, op, om, ol);
      model_tick((t <= 30) ? 6'b000010 : 6'b000000, ep, el);
      if (op[1]) npulse++;
      checks++;
      if (op !== ep || om !== 6'b0 || ol !== el) begin
        failures++;
        $display("FAIL load_hold tick=%0d press=%b level=%b required press=%b level=%b", t, op, ol, ep, el);
      end
    end
    checks++;
    if (npulse != 1) begin
      failures++;
      $display("FAIL load_hold_total pulses=%0d required 1", npulse);
    end
  endtask

  task automatic test_release_bounce_tr();
    logic [NB-1:0] pr;
    int npulse = 0, last = 0, lvl_drop = 0;
    for (int t = 1; t <= 31; t++) begin
      pr = ((t <= 12) || (t >= 15 && t <= 26)) ? 6'b001000 : 6'b000000;
      run_tick(pr, 1'b0, op, om, ol);
      model_tick(pr, ep, el);
      if (op[3]) begin npulse++; last = t; end
      if (t >= 4 && t <= 26 && ol[3] !== 1'b1) lvl_drop++;
      checks++;
      if (op !== ep || om !== 6'b0 || ol !== el) begin
        failures++;
        $display("FAIL tr_rebounce tick=%0d press=%b level=%b required press=%b level=%b", t, op, ol, ep, el);
      end
    end
    checks++;
    if (npulse != 2 || last != 25 || lvl_drop != 0) begin
      failures++;
      $display("FAIL tr_rebounce_total pulses=%0d last=%0d level_drops=%0d required 2/25/0", npulse, last, lvl_drop);
    end
  endtask

  task automatic test_reset_mid_press();
    int first = 0;
    for (int t = 1; t <= 6; t++) begin
      run_tick(6'b010000, 1'b0, op, om, ol);
      model_tick(6'b010000, ep, el);
    end
    checks++;
    if (ol[4] !== 1'b1) begin
      failures++;
      $display("FAIL bl_before_reset level4=%b required 1", ol[4]);
    end
    repeat (4) @(negedge clk_2M5);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_2M5);
    checks++;
    if (btn_level !== 6'b0 || btn_press !== 6'b0) begin
      failures++;
      $display("FAIL bl_in_reset level=%b press=%b required 000000/000000", btn_level, btn_press);
    end
    reset_n = 1'b1;
    model_reset();
    for (int t = 1; t <= 10; t++) begin
      run_tick((t <= 6) ? 6'b010000 : 6'b000000, 1'b0, op, om, ol);
      model_tick((t <= 6) ? 6'b010000 : 6'b000000, ep, el);
      if (op[4] && first == 0) first = t;
      checks++;
      if (op !== ep || om !== 6'b0 || ol !== el) begin
        failures++;
        $display("FAIL bl_after_reset tick=%0d press=%b level=%b required press=%b level=%b", t, op, ol, ep, el);
      end
    end
    checks++;
    if (first != 4) begin
      failures++;
      $display("FAIL bl_after_reset_first first_tick=%0d required 4", first);
    end
  endtask

  task automatic test_stuck_tick();
    int snap;
    for (int t = 1; t <= 5; t++) begin
      run_tick(6'b000001, 1'b0, op, om, ol);
      model_tick(6'b000001, ep, el);
    end
    snap = press_tot[0];
    buttons_n = '1;
    repeat (300) @(negedge clk_2M5);
    checks++;
    if (press_tot[0] != snap || btn_level !== 6'b000001) begin
      failures++;
      $display("FAIL stuck_tick presses=%0d level=%b required 0/000001", press_tot[0] - snap, btn_level);
    end
    for (int t = 1; t <= 5; t++) begin
      run_tick(6'b000000, 1'b0, op, om, ol);
      model_tick(6'b000000, ep, el);
      checks++;
      if (op !== ep || ol !== el) begin
        failures++;
        $display("FAIL stuck_recover tick=%0d press=%b level=%b required press=%b level=%b", t, op, ol, ep, el);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int t = 1; t <= 10; t++) begin
      run_tick((t <= 5) ? 6'b111111 : 6'b000000, 1'b0, op, om, ol);
      model_tick((t <= 5) ? 6'b111111 : 6'b000000, ep, el);
      checks++;
      if (op !== ep || om !== 6'b0 || ol !== el || (t == 4 && op !== 6'b111111)) begin
        failures++;
        $display("FAIL simultaneous tick=%0d press=%b level=%b required press=%b level=%b", t, op, ol, ep, el);
      end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] cur = '0;
    for (int t = 1; t <= 160; t++) begin
      if (t <= 155) begin
        for (int b = 0; b < NB; b++) if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      end else cur = '0;
      run_tick(cur, 1'b0, op, om, ol);
      model_tick(cur, ep, el);
      checks++;
      if (op !== ep || om !== 6'b0 || ol !== el) begin
        failures++;
        $display("FAIL random tick=%0d in=%b press=%b level=%b required press=%b level=%b", t, cur, op, ol, ep, el);
      end
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode_press();
    test_bounce();
    test_repeat_br();
    test_no_repeat_load();
    test_release_bounce_tr();
    test_reset_mid_press();
    test_stuck_tick();
    test_simultaneous();
    test_random();
    checks++;
    if (wide_tot != 0) begin
      failures++;
      $display("FAIL press_width wide_cycles=%0d required 0", wide_tot);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
